// File: rtl/sm83_alu_pkg.sv
// sm83_alu_pkg
// Shared types and constants for the SM83 nibble-sequenced ALU:
//   alu_op_t     - 4-bit operation code presented on the ALU op port
//   alu_state_t  - sequencer states (IDLE, LOW, HIGH, DONE)
//   DAA_*        - decimal-adjust correction constants and limits
//   op_is_*      - small classifiers shared by the top and the nibble slice
package sm83_alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_ADC = 4'd1,
        OP_SUB = 4'd2,
        OP_SBC = 4'd3,
        OP_AND = 4'd4,
        OP_XOR = 4'd5,
        OP_OR  = 4'd6,
        OP_CP  = 4'd7,
        OP_RLC = 4'd8,
        OP_RRC = 4'd9,
        OP_RL  = 4'd10,
        OP_RR  = 4'd11,
        OP_SLA = 4'd12,
        OP_SRA = 4'd13,
        OP_SRL = 4'd14,
        OP_DAA = 4'd15
    } alu_op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOW  = 2'd1,
        S_HIGH = 2'd2,
        S_DONE = 2'd3
    } alu_state_t;

    localparam logic [7:0] DAA_LO_CORR   = 8'h06;
    localparam logic [7:0] DAA_HI_CORR   = 8'h60;
    localparam logic [7:0] DAA_HI_LIMIT  = 8'h99;
    localparam logic [3:0] DAA_NIB_LIMIT = 4'd9;

    function automatic logic op_is_arith(alu_op_t op);
        return op inside {OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_CP};
    endfunction

    function automatic logic op_is_sub(alu_op_t op);
        return op inside {OP_SUB, OP_SBC, OP_CP};
    endfunction

    function automatic logic op_is_left(alu_op_t op);
        return op inside {OP_RLC, OP_RL, OP_SLA};
    endfunction

    function automatic logic op_is_right(alu_op_t op);
        return op inside {OP_RRC, OP_RR, OP_SRA, OP_SRL};
    endfunction

endpackage

// File: rtl/sm83_alu_nibble.sv
// sm83_alu_nibble
// Purely combinational nibble slice shared by the LOW and HIGH passes.
// Ports:
//   op    in   alu_op_t  operation (DAA never reaches here; the top remaps it)
//   a, b  in   NW        operand nibbles (b is inverted internally for subtracts)
//   cin   in   1         carry-in for arithmetic, shift-in bit for shifts
//   y     out  NW        result nibble
//   cout  out  1         raw carry-out, or the bit shifted out of the nibble
module sm83_alu_nibble
    import sm83_alu_pkg::*;
#(
    parameter int NW = 4
) (
    input  alu_op_t         op,
    input  logic [NW-1:0]   a,
    input  logic [NW-1:0]   b,
    input  logic            cin,
    output logic [NW-1:0]   y,
    output logic            cout
);

    logic [NW-1:0] b_eff;
    logic [NW:0]   sum;

    always_comb begin
        b_eff = op_is_sub(op) ? ~b : b;
        sum   = {1'b0, a} + {1'b0, b_eff} + {{NW{1'b0}}, cin};
        y     = '0;
        cout  = 1'b0;
        case (op)
            OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_CP: begin
                y    = sum[NW-1:0];
                cout = sum[NW];
            end
            OP_AND: y = a & b;
            OP_XOR: y = a ^ b;
            OP_OR:  y = a | b;
            OP_RLC, OP_RL, OP_SLA: begin
                y    = {a[NW-2:0], cin};
                cout = a[NW-1];
            end
            OP_RRC, OP_RR, OP_SRA, OP_SRL: begin
                y    = {cin, a[NW-1:1]};
                cout = a[0];
            end
            default: begin
                y    = a;
                cout = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/sm83_alu_nibble_seq.sv
// sm83_alu_nibble_seq
// Multi-cycle SM83 ALU front end: every operation runs as a LOW nibble pass
// followed by a HIGH nibble pass through one shared sm83_alu_nibble slice.
// Build option: define SM83_ALU_DAA_EN to enable decimal adjust (DAA);
// without it DAA passes `a` through and keeps the latched carry.
// Ports:
//   clk, reset_n                 clock, async active-low reset
//   start                        request; accepted only while busy=0
//   op                           alu_op_t operation
//   a_in, b_in                   operands, sampled on the accept edge
//   carry/half_carry/neg_flag_in current C/H/N, sampled on the accept edge
//   busy                         high during LOW and HIGH
//   done                         one-cycle pulse, results valid
//   result, zero_out, carry_out, half_carry_out, sign_out, shift_out,
//   daa_carry_out                registered results, held until next DONE
//
// state  | meaning
// IDLE   | waiting for start
// LOW    | low nibble pass, stores nibble result and half carry
// HIGH   | high nibble pass, outputs registered on exit
// DONE   | done pulse; start here chains straight into LOW
module sm83_alu_nibble_seq
    import sm83_alu_pkg::*;
#(
    parameter int WORD_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  alu_op_t              op,
    input  logic [WORD_SIZE-1:0] a_in,
    input  logic [WORD_SIZE-1:0] b_in,
    input  logic                 carry_flag_in,
    input  logic                 half_carry_flag_in,
    input  logic                 neg_flag_in,
    output logic                 busy,
    output logic                 done,
    output logic [WORD_SIZE-1:0] result,
    output logic                 zero_out,
    output logic                 carry_out,
    output logic                 half_carry_out,
    output logic                 sign_out,
    output logic                 shift_out,
    output logic                 daa_carry_out
);

    localparam int NW = WORD_SIZE / 2;

    alu_state_t state_q, state_d;
    logic       accept;

    alu_op_t              op_q;
    logic [WORD_SIZE-1:0] a_q, b_q;
    logic                 c_q;
    logic [NW-1:0]        lo_q;
    logic                 hc_q;    // raw carry/shift-out of the LOW pass

    alu_op_t       nib_op;
    logic [NW-1:0] nib_a, nib_b, nib_y;
    logic          nib_cin, nib_cout;
    logic          hi_pass;
    logic          carry_base, fill_left, fill_right;

    logic [WORD_SIZE-1:0] full_val, res_val;
    logic                 z_val, c_val, h_val, s_val, sh_val, dc_val;

`ifdef SM83_ALU_DAA_EN
    logic                 h_q, n_q;
    logic                 daa_lo, daa_hi;
    logic [WORD_SIZE-1:0] daa_corr;
`endif

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_LOW;
            S_LOW:   state_d = S_HIGH;
            S_HIGH:  state_d = S_DONE;
            S_DONE:  state_d = start ? S_LOW : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy   = (state_q == S_LOW) || (state_q == S_HIGH);
        done   = (state_q == S_DONE);
        accept = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    end

    // ---------------- nibble pass operand selection ----------------
`ifdef SM83_ALU_DAA_EN
    // Corrections are judged on the original operand, before any adjust.
    always_comb begin
        daa_lo   = h_q || (!n_q && (a_q[NW-1:0] > NW'(DAA_NIB_LIMIT)));
        daa_hi   = c_q || (!n_q && (a_q > WORD_SIZE'(DAA_HI_LIMIT)));
        daa_corr = (daa_lo ? WORD_SIZE'(DAA_LO_CORR) : '0)
                 | (daa_hi ? WORD_SIZE'(DAA_HI_CORR) : '0);
    end
`endif

    always_comb begin
        hi_pass    = (state_q == S_HIGH);
        carry_base = (op_q == OP_ADC || op_q == OP_SBC) ? c_q : 1'b0;

        case (op_q)
            OP_RLC:  fill_left = a_q[WORD_SIZE-1];
            OP_RL:   fill_left = c_q;
            default: fill_left = 1'b0;
        endcase
        case (op_q)
            OP_RRC:  fill_right = a_q[0];
            OP_RR:   fill_right = c_q;
            OP_SRA:  fill_right = a_q[WORD_SIZE-1];
            default: fill_right = 1'b0;
        endcase

        nib_op  = op_q;
        nib_a   = hi_pass ? a_q[WORD_SIZE-1:NW] : a_q[NW-1:0];
        nib_b   = hi_pass ? b_q[WORD_SIZE-1:NW] : b_q[NW-1:0];
        nib_cin = 1'b0;

        if (op_is_arith(op_q)) begin
            // Subtracts run as a + ~b + ~borrow; HIGH chains the raw carry.
            nib_cin = hi_pass ? hc_q : (carry_base ^ op_is_sub(op_q));
        end else if (op_is_left(op_q)) begin
            nib_cin = hi_pass ? a_q[NW-1] : fill_left;
        end else if (op_is_right(op_q)) begin
            nib_cin = hi_pass ? fill_right : a_q[NW];
        end else if (op_q == OP_DAA) begin
`ifdef SM83_ALU_DAA_EN
            nib_op  = n_q ? OP_SUB : OP_ADD;
            nib_b   = hi_pass ? daa_corr[WORD_SIZE-1:NW] : daa_corr[NW-1:0];
            nib_cin = hi_pass ? hc_q : n_q;
`else
            nib_op  = OP_OR;
            nib_b   = '0;
`endif
        end
    end

    sm83_alu_nibble #(.NW(NW)) u_nibble (
        .op   (nib_op),
        .a    (nib_a),
        .b    (nib_b),
        .cin  (nib_cin),
        .y    (nib_y),
        .cout (nib_cout)
    );

    // ---------------- final result/flags, valid during HIGH ----------------
    always_comb begin
        full_val = {nib_y, lo_q};
        res_val  = (op_q == OP_CP) ? a_q : full_val;
        z_val    = (full_val == '0);
        s_val    = full_val[WORD_SIZE-1];
        c_val    = 1'b0;
        h_val    = 1'b0;
        sh_val   = 1'b0;
        dc_val   = 1'b0;

        if (op_is_arith(op_q)) begin
            h_val = op_is_sub(op_q) ? ~hc_q : hc_q;
            c_val = op_is_sub(op_q) ? ~nib_cout : nib_cout;
        end else if (op_q == OP_AND) begin
            h_val = 1'b1;
        end else if (op_is_left(op_q)) begin
            sh_val = nib_cout;
            c_val  = nib_cout;
        end else if (op_is_right(op_q)) begin
            // Right shifts lose bit 0, which fell out during the LOW pass.
            sh_val = hc_q;
            c_val  = hc_q;
        end else if (op_q == OP_DAA) begin
`ifdef SM83_ALU_DAA_EN
            c_val  = daa_hi;
            dc_val = daa_hi;
`else
            c_val  = c_q;
`endif
        end
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q           <= OP_ADD;
            a_q            <= '0;
            b_q            <= '0;
            c_q            <= 1'b0;
            lo_q           <= '0;
            hc_q           <= 1'b0;
            result         <= '0;
            zero_out       <= 1'b0;
            carry_out      <= 1'b0;
            half_carry_out <= 1'b0;
            sign_out       <= 1'b0;
            shift_out      <= 1'b0;
            daa_carry_out  <= 1'b0;
        end else begin
            if (accept) begin
                op_q <= op;
                a_q  <= a_in;
                b_q  <= b_in;
                c_q  <= carry_flag_in;
            end
            if (state_q == S_LOW) begin
                lo_q <= nib_y;
                hc_q <= nib_cout;
            end
            if (state_q == S_HIGH) begin
                result         <= res_val;
                zero_out       <= z_val;
                carry_out      <= c_val;
                half_carry_out <= h_val;
                sign_out       <= s_val;
                shift_out      <= sh_val;
                daa_carry_out  <= dc_val;
            end
        end
    end

`ifdef SM83_ALU_DAA_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h_q <= 1'b0;
            n_q <= 1'b0;
        end else if (accept) begin
            h_q <= half_carry_flag_in;
            n_q <= neg_flag_in;
        end
    end
`endif

endmodule

// File: tb/tb_sm83_alu_nibble_seq.sv
module tb_sm83_alu_nibble_seq;
    import sm83_alu_pkg::*;

    typedef struct packed {
        logic [7:0] r;
        logic z, c, h, s, sh, dc;
    } outs_t;

    logic       clk, reset_n, start;
    alu_op_t    op;
    logic [7:0] a_in, b_in;
    logic       cf, hf, nf;
    logic       busy, done;
    logic [7:0] result;
    logic       zero_out, carry_out, half_carry_out, sign_out, shift_out, daa_carry_out;

    int n_checks = 0;
    int n_pass   = 0;
    int done_count = 0;

    sm83_alu_nibble_seq #(.WORD_SIZE(8)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .op(op),
        .a_in(a_in), .b_in(b_in),
        .carry_flag_in(cf), .half_carry_flag_in(hf), .neg_flag_in(nf),
        .busy(busy), .done(done), .result(result),
        .zero_out(zero_out), .carry_out(carry_out), .half_carry_out(half_carry_out),
        .sign_out(sign_out), .shift_out(shift_out), .daa_carry_out(daa_carry_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: whole-byte arithmetic straight from the operation rules.
    function automatic outs_t model(alu_op_t o, logic [7:0] a, logic [7:0] b,
                                    logic c, logic h, logic n);
        outs_t      r;
        logic [7:0] v;
        int         ci, s, corr;
        logic       lo, hi;
        r  = '0;
        v  = 8'h00;
        ci = 0;
        case (o)
            OP_ADD, OP_ADC: begin
                ci = (o == OP_ADC && c) ? 1 : 0;
                s  = int'(a) + int'(b) + ci;
                v  = 8'(s);
                r.c = (s > 255);
                r.h = (int'(a[3:0]) + int'(b[3:0]) + ci) > 15;
            end
            OP_SUB, OP_SBC, OP_CP: begin
                ci = (o == OP_SBC && c) ? 1 : 0;
                s  = int'(a) - int'(b) - ci;
                v  = 8'(s);
                r.c = (s < 0);
                r.h = (int'(a[3:0]) - int'(b[3:0]) - ci) < 0;
            end
            OP_AND: begin v = a & b; r.h = 1'b1; end
            OP_XOR: v = a ^ b;
            OP_OR:  v = a | b;
            OP_RLC: begin v = {a[6:0], a[7]}; r.sh = a[7]; end
            OP_RL:  begin v = {a[6:0], c};    r.sh = a[7]; end
            OP_SLA: begin v = {a[6:0], 1'b0}; r.sh = a[7]; end
            OP_RRC: begin v = {a[0], a[7:1]}; r.sh = a[0]; end
            OP_RR:  begin v = {c, a[7:1]};    r.sh = a[0]; end
            OP_SRA: begin v = {a[7], a[7:1]}; r.sh = a[0]; end
            OP_SRL: begin v = {1'b0, a[7:1]}; r.sh = a[0]; end
            default: begin
`ifdef SM83_ALU_DAA_EN
                lo   = h || (!n && a[3:0] > 4'd9);
                hi   = c || (!n && a > 8'h99);
                corr = (lo ? 6 : 0) + (hi ? 96 : 0);
                s    = n ? int'(a) - corr : int'(a) + corr;
                v    = 8'(s);
                r.c  = hi;
                r.dc = hi;
`else
                lo  = h;
                hi  = n;
                v   = a;
                r.c = c;
                if (lo & hi) corr = 0;
`endif
            end
        endcase
        if (o inside {OP_RLC, OP_RL, OP_SLA, OP_RRC, OP_RR, OP_SRA, OP_SRL}) r.c = r.sh;
        r.r = (o == OP_CP) ? a : v;
        r.z = (v == 8'h00);
        r.s = v[7];
        return r;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Timing model: phase 0 = can accept, 1 = first pass, 2 = second pass.
    int    m_phase;
    logic  m_done;
    outs_t m_out, m_pend;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_phase <= 0;
            m_done  <= 1'b0;
            m_out   <= '0;
            m_pend  <= '0;
        end else begin
            m_done <= 1'b0;
            case (m_phase)
                0: if (start) begin
                    m_pend  <= model(op, a_in, b_in, cf, hf, nf);
                    m_phase <= 1;
                end
                1: m_phase <= 2;
                default: begin
                    m_phase <= 0;
                    m_done  <= 1'b1;
                    m_out   <= m_pend;
                end
            endcase
        end
    end

    outs_t dut_out;
    assign dut_out = {result, zero_out, carry_out, half_carry_out, sign_out, shift_out, daa_carry_out};

    always @(negedge clk) begin
        check("done", {15'd0, done}, {15'd0, m_done});
        check("busy", {15'd0, busy}, {15'd0, (m_phase != 0)});
        check("outputs", {2'b00, dut_out}, {2'b00, m_out});
        if (done) done_count++;
    end

    task automatic scramble();
        a_in = 8'($urandom); b_in = 8'($urandom);
        cf = 1'($urandom); hf = 1'($urandom); nf = 1'($urandom);
        op = alu_op_t'($urandom_range(0, 15));
    endtask

    task automatic run_op(input alu_op_t o, input logic [7:0] a, input logic [7:0] b,
                          input logic c, input logic h, input logic n);
        @(negedge clk);
        op = o; a_in = a; b_in = b; cf = c; hf = h; nf = n; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        scramble();
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        reset_n = 1'b0; start = 1'b0;
        op = OP_ADD; a_in = 8'h00; b_in = 8'h00; cf = 1'b0; hf = 1'b0; nf = 1'b0;

        // Hand-computed pins on the reference itself.
        check("pin_add",  16'(model(OP_ADD, 8'h3A, 8'hC6, 1'b0, 1'b0, 1'b0)), {2'b00, 8'h00, 6'b111000});
        check("pin_sub",  16'(model(OP_SUB, 8'h10, 8'h01, 1'b0, 1'b0, 1'b0)), {2'b00, 8'h0F, 6'b001000});
        check("pin_sbc",  16'(model(OP_SBC, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0)), {2'b00, 8'hFF, 6'b011100});
        check("pin_cp",   16'(model(OP_CP,  8'h05, 8'h05, 1'b0, 1'b0, 1'b0)), {2'b00, 8'h05, 6'b100000});
        check("pin_and",  16'(model(OP_AND, 8'hF0, 8'h0F, 1'b0, 1'b0, 1'b0)), {2'b00, 8'h00, 6'b101000});
        check("pin_rlc",  16'(model(OP_RLC, 8'h85, 8'h00, 1'b0, 1'b0, 1'b0)), {2'b00, 8'h0B, 6'b010010});
        check("pin_rr",   16'(model(OP_RR,  8'h01, 8'h00, 1'b0, 1'b0, 1'b0)), {2'b00, 8'h00, 6'b110010});
`ifdef SM83_ALU_DAA_EN
        check("pin_daa",  16'(model(OP_DAA, 8'h9A, 8'h00, 1'b0, 1'b0, 1'b0)), {2'b00, 8'h00, 6'b110001});
`else
        check("pin_daa",  16'(model(OP_DAA, 8'h9A, 8'h00, 1'b0, 1'b0, 1'b0)), {2'b00, 8'h9A, 6'b000100});
`endif

        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;

        // Directed cases; the per-cycle compare process checks each result.
        run_op(OP_ADD, 8'h3A, 8'hC6, 1'b0, 1'b0, 1'b0);
        run_op(OP_SUB, 8'h10, 8'h01, 1'b0, 1'b0, 1'b0);
        run_op(OP_SBC, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
        run_op(OP_CP,  8'h05, 8'h05, 1'b0, 1'b0, 1'b0);
        run_op(OP_AND, 8'hF0, 8'h0F, 1'b0, 1'b0, 1'b0);
        run_op(OP_RLC, 8'h85, 8'h00, 1'b0, 1'b0, 1'b0);
        run_op(OP_RR,  8'h01, 8'h00, 1'b0, 1'b0, 1'b0);
        run_op(OP_DAA, 8'h9A, 8'h00, 1'b0, 1'b0, 1'b0);
        run_op(OP_DAA, 8'h15, 8'h00, 1'b1, 1'b1, 1'b1);

        // start held high for 6 cycles -> two operations.
        d0 = done_count;
        @(negedge clk);
        op = OP_ADD; a_in = 8'h12; b_in = 8'h34; start = 1'b1;
        repeat (6) @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("held_start_dones", 16'(done_count - d0), 16'd2);

        // Reset during the HIGH pass aborts the operation.
        @(negedge clk);
        op = OP_OR; a_in = 8'hA5; b_in = 8'h5A; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        d0 = done_count;
        @(posedge clk);
        #2 reset_n = 1'b0;
        @(negedge clk);
        check("reset_outputs", {2'b00, dut_out}, 16'd0);
        check("reset_done_busy", {14'd0, done, busy}, 16'd0);
        @(posedge clk);
        #2 reset_n = 1'b1;
        repeat (4) @(negedge clk);
        check("reset_no_done", 16'(done_count - d0), 16'd0);
        run_op(OP_XOR, 8'hFF, 8'h0F, 1'b0, 1'b0, 1'b0);

        // Randomized traffic: start toggles freely, inputs change every cycle.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            start = ($urandom_range(0, 2) != 0);
            scramble();
        end
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sm83_alu_nibble_seq.md
# sm83_alu_nibble_seq

Multi-cycle 8-bit ALU front end for the SM83 core. It executes each operation as two 4-bit passes, low nibble then high nibble, through one shared nibble core. The low-nibble carry between passes is the half carry. It feeds the flag register stage with `zero_in`, `carry_in`, `shift_out_in`, `daa_carry_in` and `sign_in`, and consumes that stage's current `carry`, `half_carry` and `neg` as operand flags.

## Interface
Parameters:
- `WORD_SIZE`, default 8: datapath width; must be even; nibble width is `WORD_SIZE/2`.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a new operation; accepted only while `busy`=0.
- `op`  in  4  `alu_op_t`: ADD, ADC, SUB, SBC, AND, XOR, OR, CP, RLC, RRC, RL, RR, SLA, SRA, SRL, DAA.
- `a_in`, `b_in`  in  WORD_SIZE  operands, sampled only on the accept edge.
- `carry_flag_in`, `half_carry_flag_in`, `neg_flag_in`  in  1  current C/H/N flags, sampled only on the accept edge.
- `busy`  out  1  high in LOW and HIGH states.
- `done`  out  1  one-cycle pulse; result outputs are valid.
- `result`  out  WORD_SIZE  operation result.
- `zero_out`, `carry_out`, `half_carry_out`, `sign_out`, `shift_out`, `daa_carry_out`  out  1  flag results.

## Operation
- FSM states: IDLE → LOW → HIGH → DONE, then back to IDLE.
  - From DONE, `start`=1 goes directly to LOW.
  - From IDLE, `start`=1 goes to LOW; otherwise the FSM stays in IDLE.
- Accept edge: latch `op`, the operands and the three flags.
- ADD/ADC/SUB/SBC/CP:
  - Subtract forms invert `b` and invert the carry-in.
  - Carry-in is 0 for ADD/SUB/CP, `carry_flag_in` for ADC and SBC.
  - LOW pass: store the low result nibble and the nibble carry (H).
  - HIGH pass: chain H as carry-in and produce C.
  - Subtract forms report borrow, so H and C are the inverted raw nibble carries.
- CP: flags are computed as for SUB; `result` = `a_in`.
- Logic ops: AND gives H=1, C=0; OR and XOR give H=0, C=0.
- Shifts (H=0, `carry_out` = `shift_out`):
  - RLC {a[6:0],a[7]}; RL {a[6:0],Cin}; SLA {a[6:0],0}.
  - RRC {a[0],a[7:1]}; RR {Cin,a[7:1]}; SRA {a[7],a[7:1]}; SRL {0,a[7:1]}.
  - `shift_out` = a[7] for left shifts, a[0] for right shifts.
- For every op other than DAA:
  - `zero_out` = (computed value == 0).
  - `sign_out` = computed value MSB.
  - `daa_carry_out` = 0.
  - For non-shift ops, `shift_out` = 0.
- Outputs are registered at the HIGH→DONE edge and held until the next such edge.

## Timing
- Latency: `start` sampled at edge N; `done`=1 during the cycle after edge N+2 (3 cycles).
- Throughput: one operation per 3 cycles when `start` is held high.
- `start` is ignored while `busy`=1; there is no queueing.
- `done` and `busy` are never high in the same cycle.
- Reset values: state IDLE; `busy`=0, `done`=0; `result`=0; every flag output 0.
- Reset asserted mid-operation aborts immediately: no `done` is emitted and outputs return to their reset values.
- Operand inputs may change freely after the accept edge.

## Configuration
- `SM83_ALU_DAA_EN` defined: DAA uses the latched `a`, H and N flags.
  - Low correction 0x06 if H, or if !N and a[3:0]>9.
  - High correction 0x60 if C, or if !N and a>0x99.
  - Corrections are added when N=0 and subtracted when N=1.
  - `daa_carry_out` = `carry_out` = C | (!N & a>0x99).
  - `half_carry_out` = 0; `zero_out` per result.
- `SM83_ALU_DAA_EN` undefined: DAA is a no-op.
  - `result` = `a`, `carry_out` = latched C, `daa_carry_out` = 0, H=0.
  - `zero_out` and `sign_out` follow `a`.
  - The correction logic is absent.

## Structure
- Package `sm83_alu_pkg`: `alu_op_t` enum, FSM state enum, and the DAA constants (0x06, 0x60, 0x99, nibble limit 9).
- Sub-module `sm83_alu_nibble`: purely combinational 4-bit add/logic/shift slice with carry in/out, instantiated once and shared by the LOW and HIGH passes.

## Test plan
- ADD a=0x3A b=0xC6 → `result`=0x00, Z=1, H=1, C=1; `done` exactly 3 cycles after `start`.
- SUB a=0x10 b=0x01 → 0x0F, H=1, C=0, `sign_out`=0. SBC a=0x00 b=0x00 with C=1 → 0xFF, H=1, C=1, `sign_out`=1.
- CP a=0x05 b=0x05 → Z=1, `result`=0x05. AND a=0xF0 b=0x0F → 0x00, Z=1, H=1, C=0.
- RLC a=0x85 → 0x0B, `shift_out`=1, C=1. RR a=0x01 with C=0 → 0x00, Z=1, C=1.
- DAA with `SM83_ALU_DAA_EN`: a=0x9A, N=0, H=0, C=0 → 0x00, `daa_carry_out`=1, Z=1. Same stimulus without the macro → 0x9A, C=0.
- Hold `start` high for 6 cycles → exactly 2 `done` pulses. Drop `reset_n` in HIGH → no `done`, all outputs 0, next op executes normally.
